multi_servo: RTL and testbench

MULTI_SERVO -- requirements
Module: multi_servo

---
 rtl/servo_pkg.sv | 25 ++
 rtl/servo_us_tick.sv | 30 +++
 rtl/multi_servo.sv | 112 +++++++++++
 tb/tb_multi_servo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo pulse generator: FSM encoding,
// timing defaults and a helper for index-port widths.
package servo_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  localparam int US_NS = 1000;

  localparam int DEF_CLK_PER_NS = 40;
  localparam int DEF_NCH        = 4;
  localparam int DEF_N          = 8;
  localparam int DEF_MIN_US     = 1000;
  localparam int DEF_SPAN_US    = 1000;
  localparam int DEF_FRAME_US   = 20000;

  // Width of an index able to address n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/servo_us_tick.sv
// Microsecond prescaler: one-cycle tick every DIV clocks while enabled,
// counter held at zero while disabled.
module servo_us_tick #(
  parameter int DIV = 25
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (!en_i || cnt_q == CW'(DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/multi_servo.sv
// Multi-channel RC servo pulse generator: one shared frame FSM and us counter,
// per-channel pending/shadow position registers and registered compare outputs.
module multi_servo
  import servo_pkg::*;
#(
  parameter int CLK_PER_NS = DEF_CLK_PER_NS,
  parameter int NCH        = DEF_NCH,
  parameter int N          = DEF_N,
  parameter int MIN_US     = DEF_MIN_US,
  parameter int SPAN_US    = DEF_SPAN_US,
  parameter int FRAME_US   = DEF_FRAME_US
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic [NCH-1:0]          ch_en_i,
  input  logic                    wr_i,
  input  logic [idx_w(NCH)-1:0]   wr_ch_i,
  input  logic [N-1:0]            wr_pos_i,
  output logic [NCH-1:0]          srv_o,
  output logic                    frame_o
);

  localparam int DIV = US_NS / CLK_PER_NS;
  localparam int CHW = idx_w(NCH);
  localparam int CW  = $clog2(FRAME_US);
  localparam int PW  = N + $clog2(SPAN_US + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] us_cnt_q, us_cnt_d;
  logic          tick;
  logic          frame_q;

  servo_us_tick #(.DIV(DIV)) u_tick (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (en_i),
    .tick_o (tick)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    us_cnt_d = us_cnt_q;
    if (!en_i) begin
      state_d  = S_IDLE;
      us_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (tick) state_d = S_LOAD;
        S_LOAD: begin
          state_d  = S_RUN;
          us_cnt_d = '0;
        end
        S_RUN: if (tick) begin
          if (us_cnt_q == CW'(FRAME_US - 1)) begin
            state_d  = S_LOAD;
            us_cnt_d = '0;
          end else begin
            us_cnt_d = us_cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      us_cnt_q <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      us_cnt_q <= us_cnt_d;
      frame_q  <= (state_d == S_LOAD);
    end
  end

  assign frame_o = frame_q;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [N-1:0]  pending_q;
    logic [CW-1:0] shadow_q;
    logic [PW-1:0] prod;
    logic [CW-1:0] width;
    logic          srv_q;

    assign prod  = PW'(pending_q) * PW'(SPAN_US);
    assign width = CW'(MIN_US) + CW'(prod >> N);

    // NOTE: position registers are real reset flops (not RAM), so they get
    // defined power-on values: mid position pending, minimum-width shadow.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        pending_q <= N'(1 << (N - 1));
        shadow_q  <= CW'(MIN_US);
        srv_q     <= 1'b0;
      end else begin
        if (wr_i && wr_ch_i == CHW'(ch)) pending_q <= wr_pos_i;
        // Shadow samples the pre-edge pending value, so a write in the
        // load cycle only takes effect from the following frame.
        if (state_q == S_LOAD) shadow_q <= width;
        srv_q <= en_i && (state_q == S_RUN) && ch_en_i[ch] && (us_cnt_q < shadow_q);
      end
    end

    assign srv_o[ch] = srv_q;
  end

endmodule

// File: tb/tb_multi_servo.sv
// Self-checking bench for multi_servo with scaled timing; pulse widths and
// frame periods are compared against a position-to-microsecond model.
`timescale 1ns/1ps
module tb_multi_servo;
  import servo_pkg::*;

  localparam int CLK_PER_NS = 250;
  localparam int NCH        = 3;
  localparam int N          = 4;
  localparam int MIN_US     = 8;
  localparam int SPAN_US    = 20;
  localparam int FRAME_US   = 40;
  localparam int DIV        = US_NS / CLK_PER_NS;
  localparam int FRAME_CLK  = FRAME_US * DIV;
  localparam int CHW        = idx_w(NCH);

  logic           clk = 1'b0;
  logic           rstn;
  logic           en;
  logic [NCH-1:0] ch_en;
  logic           wr;
  logic [CHW-1:0] wr_ch;
  logic [N-1:0]   wr_pos;
  logic [NCH-1:0] srv;
  logic           frame;

  int checks   = 0;
  int failures = 0;
  int model_pend [NCH];
  int exp_us     [NCH];
  int hi_cnt     [NCH];
  int period_cnt;

  multi_servo #(
    .CLK_PER_NS (CLK_PER_NS), .NCH (NCH), .N (N),
    .MIN_US (MIN_US), .SPAN_US (SPAN_US), .FRAME_US (FRAME_US)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .en_i     (en),
    .ch_en_i  (ch_en),
    .wr_i     (wr),
    .wr_ch_i  (wr_ch),
    .wr_pos_i (wr_pos),
    .srv_o    (srv),
    .frame_o  (frame)
  );

  always #(CLK_PER_NS / 2) clk = ~clk;

  function automatic int width_us(input int pos);
    return MIN_US + (pos * SPAN_US) / (2 ** N);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse lengths may differ from the ideal by one clock.
  task automatic check_near(input string tag, input int obs, input int exp);
    checks++;
    assert (obs >= exp - 1 && obs <= exp + 1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d(+-1)", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int c = 0; c < NCH; c++) model_pend[c] = 2 ** (N - 1);
  endtask

  // Advances to the next negedge where frame_o is seen; returns cycles taken.
  task automatic wait_frame(input string tag, output int n);
    int found;
    n = 0;
    found = 0;
    while (!found && n < 2 * FRAME_CLK + 10) begin
      @(negedge clk);
      n++;
      if (frame === 1'b1) found = 1;
    end
    check({tag, "_frame_seen"}, found, 1);
  endtask

  // Starting at a frame_o negedge, runs to the next one, counting high
  // cycles per channel; optionally issues one write at cycle wr_at.
  task automatic measure_frame(input int wr_at, input int wch, input int wpos);
    int k;
    int done;
    k = 0;
    done = 0;
    period_cnt = 0;
    for (int c = 0; c < NCH; c++) hi_cnt[c] = 0;
    while (!done && k < 2 * FRAME_CLK) begin
      if (k == wr_at) begin
        wr = 1'b1; wr_ch = CHW'(wch); wr_pos = N'(wpos);
      end else begin
        wr = 1'b0;
      end
      @(negedge clk);
      k++;
      for (int c = 0; c < NCH; c++) if (srv[c] === 1'b1) hi_cnt[c]++;
      if (frame === 1'b1) done = 1;
    end
    wr = 1'b0;
    period_cnt = k;
  endtask

  task automatic frame_and_check(input string tag, input int wr_at, input int wch,
                                 input int wpos);
    for (int c = 0; c < NCH; c++) exp_us[c] = width_us(model_pend[c]);
    measure_frame(wr_at, wch, wpos);
    check({tag, "_period"}, period_cnt, FRAME_CLK);
    for (int c = 0; c < NCH; c++)
      check_near($sformatf("%s_ch%0d_width", tag, c), hi_cnt[c], exp_us[c] * DIV);
    if (wr_at >= 0 && wch < NCH) model_pend[wch] = wpos;
  endtask

  task automatic step_to(input int from, input int to);
    for (int k = from; k < to; k++) @(negedge clk);
  endtask

  initial begin
    int n;
    int fr_hi;
    int srv_hi;
    rstn = 1'b0; en = 1'b1; ch_en = '1; wr = 1'b0; wr_ch = '0; wr_pos = '0;
    reset_model();

    // Reset state and first frame latency.
    repeat (3) @(negedge clk);
    check("rst_srv", int'(srv), 0);
    check("rst_frame", int'(frame), 0);
    rstn = 1'b1;
    wait_frame("first", n);
    check("first_frame_latency", n, DIV);

    // Mid-position defaults, then mid-frame writes applying one frame later.
    frame_and_check("default", -1, 0, 0);
    frame_and_check("wr_ch2_mid", 40, 2, 0);
    frame_and_check("wr_ch1_mid", 60, 1, 15);
    // Write in the load cycle, then an out-of-range channel write.
    frame_and_check("wr_load_cycle", 0, 0, 0);
    frame_and_check("wr_bad_ch", 10, 3, 0);
    frame_and_check("after_bad_ch", -1, 0, 0);

    // Randomised positions, channels (including invalid) and write cycles.
    for (int i = 0; i < 4; i++)
      frame_and_check($sformatf("rand%0d", i), int'($urandom_range(0, FRAME_CLK - 10)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2 ** N - 1)));

    // Long pulse on ch1, short on ch2, for the per-channel enable tests.
    frame_and_check("set_ch1", 5, 1, 2 ** N - 1);
    frame_and_check("set_ch2", 5, 2, 0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 10) ch_en[2] = 1'b0;
      if (k == 12) check("ch2_off", int'(srv[2]), 0);
      if (k == 20) ch_en[1] = 1'b0;
      if (k == 22) check("ch1_off_midpulse", int'(srv[1]), 0);
      if (k == 30) ch_en[1] = 1'b1;
      if (k == 32) check("ch1_resume", int'(srv[1]), 1);
      if (k == 50) ch_en[2] = 1'b1;
      if (k == 52) check("ch2_no_resume_after_width", int'(srv[2]), 0);
    end
    wait_frame("chen_end", n);

    // Global disable mid-pulse, then re-enable with retained positions.
    step_to(0, 30);
    check("pre_disable_ch1_high", int'(srv[1]), 1);
    en = 1'b0;
    step_to(0, 2);
    check("disable_srv_low", int'(srv), 0);
    fr_hi = 0;
    srv_hi = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame !== 1'b0) fr_hi++;
      if (srv !== '0) srv_hi++;
    end
    check("disabled_frame_silent", fr_hi, 0);
    check("disabled_srv_silent", srv_hi, 0);
    en = 1'b1;
    wait_frame("reenable", n);
    check("reenable_latency", n, DIV);
    frame_and_check("retained", -1, 0, 0);

    // Asynchronous reset in the middle of a pulse.
    step_to(0, 30);
    check("pre_reset_ch1_high", int'(srv[1]), 1);
    rstn = 1'b0;
    #1;
    check("async_reset_srv", int'(srv), 0);
    check("async_reset_frame", int'(frame), 0);
    reset_model();
    step_to(0, 3);
    rstn = 1'b1;
    wait_frame("post_reset", n);
    check("post_reset_latency", n, DIV);
    frame_and_check("post_reset_mid", -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
